// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DROP  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_sva.sv
// Protocol checker for fetch_stage: read data may only arrive while a request is outstanding.
module fetch_stage_sva
  import fetch_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input fetch_state_t state_i,
  input logic         imem_rvalid_i
);

  // A response is legal only in WAIT or DROP.
  a_rvalid_expected : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (state_i == WAIT || state_i == DROP))
    else $error("fetch_stage: imem_rvalid outside WAIT/DROP");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight, hands words to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;

  // Next-state logic; flush overrides every other event and may leave one response to drop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      pc_d = word_align(flush_pc);
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt    ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ  : DROP;
        VALID:   state_d = REQ;
        DROP:    state_d = imem_rvalid ? REQ  : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt) state_d = WAIT;
          else          state_d = REQ;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = VALID;
          end else begin
            state_d = WAIT;
          end
        end
        VALID: begin
          if (id_ready) begin
            pc_d    = word_align(next_pc);
            state_d = REQ;
          end else begin
            state_d = VALID;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = REQ;
          else             state_d = DROP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= word_align(RESET_PC);
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign id_valid  = (state_q == VALID);
  assign pc_o      = pc_q;
  assign instr_o   = instr_q;

  fetch_stage_sva u_sva (
    .clk           (clk),
    .rst_n         (rst_n),
    .state_i       (state_q),
    .imem_rvalid_i (imem_rvalid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] pc_o;
  logic [31:0] instr_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .pc_o        (pc_o),
    .instr_o     (instr_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting in REQ at addr: optional gnt delay, then WAIT, then VALID with optional decode stall.
  task automatic go_valid(input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_delay, input int stall);
    for (int i = 0; i < gnt_delay; i++) begin
      imem_gnt = 1'b0;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
        n_err++;
        $display("FAIL req_hold: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, addr);
      end
      step();
    end
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== addr || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL req_state: req=%b addr=%h idv=%b, want 1 %h 0", imem_req, imem_addr, id_valid, addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wait_state: req=%b idv=%b, want 0 0", imem_req, id_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0BAD_F00D;
    for (int i = 0; i <= stall; i++) begin
      n_vec++;
      if (id_valid !== 1'b1 || pc_o !== addr || instr_o !== data || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL valid_state: idv=%b pc=%h instr=%h req=%b, want 1 %h %h 0",
                 id_valid, pc_o, instr_o, imem_req, addr, data);
      end
      if (i < stall) begin
        id_ready = 1'b0;
        step();
      end
    end
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int gnt_delay,
                           input int stall, input logic [31:0] npc, input logic [31:0] exp_next);
    go_valid(addr, data, gnt_delay, stall);
    id_ready = 1'b1;
    next_pc  = npc;
    step();
    id_ready = 1'b0;
    next_pc  = 32'hFFFF_FFF0;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== exp_next || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL next_req: req=%b addr=%h idv=%b, want 1 %h 0", imem_req, imem_addr, id_valid, exp_next);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; next_pc = 32'h0; flush = 1'b0; flush_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    step();
    step();
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0 ||
        pc_o !== 32'h0 || instr_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_vals: req=%b addr=%h idv=%b pc=%h instr=%h, want 0 0 0 0 0",
               imem_req, imem_addr, id_valid, pc_o, instr_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    fetch_one(32'h0, 32'h1111_0001, 0, 0, 32'h4, 32'h4);
    fetch_one(32'h4, 32'h2222_0002, 0, 0, 32'h8, 32'h8);
  endtask

  task automatic test_gnt_delay();
    fetch_one(32'h8, 32'h3333_0003, 4, 0, 32'hC, 32'hC);
  endtask

  task automatic test_decode_stall();
    // Low bits of next_pc must be dropped.
    fetch_one(32'hC, 32'h4444_0004, 0, 5, 32'h43, 32'h40);
  endtask

  task automatic test_flush_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h83;
    step();
    flush = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'h80) begin
      n_err++;
      $display("FAIL flush_drop: req=%b idv=%b addr=%h, want 0 0 00000080", imem_req, id_valid, imem_addr);
    end
    step();
    n_vec++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_hold: req=%b idv=%b, want 0 0", imem_req, id_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_vec++;
    if (id_valid !== 1'b0 || instr_o === 32'hDEAD_BEEF || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      n_err++;
      $display("FAIL drop_discard: idv=%b instr=%h req=%b addr=%h, want 0 !deadbeef 1 00000080",
               id_valid, instr_o, imem_req, imem_addr);
    end
    fetch_one(32'h80, 32'h5555_0005, 0, 0, 32'h84, 32'h84);
  endtask

  task automatic test_flush_valid();
    go_valid(32'h84, 32'h6666_0006, 0, 0);
    id_ready = 1'b1;
    next_pc  = 32'h10;
    flush    = 1'b1;
    flush_pc = 32'h200;
    step();
    id_ready = 1'b0;
    flush    = 1'b0;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || pc_o !== 32'h200 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_priority: req=%b addr=%h pc=%h idv=%b, want 1 00000200 00000200 0",
               imem_req, imem_addr, pc_o, id_valid);
    end
  endtask

  task automatic test_async_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0 ||
        pc_o !== 32'h0 || instr_o !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: req=%b addr=%h idv=%b pc=%h instr=%h, want 0 0 0 0 0",
               imem_req, imem_addr, id_valid, pc_o, instr_o);
    end
    step();
    rst_n = 1'b1;
    step();
    fetch_one(32'h0, 32'h7777_0007, 0, 0, 32'h4, 32'h4);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gnt_delay();
    test_decode_stall();
    test_flush_wait();
    test_flush_valid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
